// File: rtl/alu_issue_unit_if.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_unit_if
// Brief  : Instruction-in handshake and ALU-facing issue bus of alu_issue_unit.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_issue_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_instr;
  logic [3:0]  addr1;
  logic [3:0]  addr2;
  logic [3:0]  rd;
  logic [2:0]  func;
  logic [7:0]  memaddr;
  logic        write;
  logic        issue_valid;
  logic [15:0] issued_cnt;
  logic [15:0] stall_cnt;
  logic        err_rsvd;

  modport master (
    output in_valid, in_instr,
    input  in_ready, addr1, addr2, rd, func, memaddr, write,
    input  issue_valid, issued_cnt, stall_cnt, err_rsvd
  );

  modport slave (
    input  in_valid, in_instr,
    output in_ready, addr1, addr2, rd, func, memaddr, write,
    output issue_valid, issued_cnt, stall_cnt, err_rsvd
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_issue_unit
// Brief  : FIFO-buffered issue stage for the 8-bit ALU with RAW stall logic.
// Rev    : 1.0  initial release
// ============================================================================
module alu_issue_unit #(
  parameter int         FIFO_DEPTH   = 4,
  parameter int         HAZARD_DEPTH = 2,
  parameter logic [3:0] NOP_REG      = 4'hF
) (
  input  wire logic       clk1,
  input  wire logic       rst_n,
  alu_issue_unit_if.slave bus
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_STALL    = 2'd2;
  localparam logic [2:0] C_FUNC_XOR = 3'b100;

  logic [23:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic [1:0]  r_state;
  logic [3:0]  r_addr1;
  logic [3:0]  r_addr2;
  logic [3:0]  r_rd;
  logic [2:0]  r_func;
  logic [7:0]  r_memaddr;
  logic        r_write;
  logic [15:0] r_issued_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_err_rsvd;
  logic        r_sb_v  [HAZARD_DEPTH];
  logic [3:0]  r_sb_rd [HAZARD_DEPTH];

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_hazard;
  logic [23:0] w_head;
  logic [1:0]  w_state_next;
  logic [3:0]  w_addr1_next;
  logic [3:0]  w_addr2_next;
  logic [3:0]  w_rd_next;
  logic [2:0]  w_func_next;
  logic [7:0]  w_memaddr_next;
  logic        w_write_next;
  logic        w_valid_next;

  // Extra MSB on the pointers tells full from empty when the low bits match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = rst_n && bus.in_valid && !w_full;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < HAZARD_DEPTH; k++) begin
      if (r_sb_v[k] && ((w_head[16:13] == r_sb_rd[k]) ||
                        (w_head[12:9]  == r_sb_rd[k]))) begin
        w_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = S_EMPTY;
    if (!w_empty) begin
      w_state_next = w_hazard ? S_STALL : S_ISSUE;
    end
  end

  // Decodes the upcoming state into the values the ports take at the next edge.
  always_comb begin
    w_addr1_next   = NOP_REG;
    w_addr2_next   = NOP_REG;
    w_rd_next      = NOP_REG;
    w_func_next    = C_FUNC_XOR;
    w_memaddr_next = 8'd0;
    w_write_next   = 1'b0;
    w_valid_next   = 1'b0;
    w_pop          = 1'b0;
    if (w_state_next == S_ISSUE) begin
      w_func_next    = w_head[23:21];
      w_rd_next      = w_head[20:17];
      w_addr1_next   = w_head[16:13];
      w_addr2_next   = w_head[12:9];
      w_write_next   = w_head[8];
      w_memaddr_next = w_head[7:0];
      w_valid_next   = 1'b1;
      w_pop          = 1'b1;
    end
  end

  always_ff @(posedge clk1) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= bus.in_instr;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_addr1      <= NOP_REG;
      r_addr2      <= NOP_REG;
      r_rd         <= NOP_REG;
      r_func       <= C_FUNC_XOR;
      r_memaddr    <= 8'd0;
      r_write      <= 1'b0;
      r_issued_cnt <= 16'd0;
      r_stall_cnt  <= 16'd0;
      r_err_rsvd   <= 1'b0;
      for (int k = 0; k < HAZARD_DEPTH; k++) begin
        r_sb_v[k]  <= 1'b0;
        r_sb_rd[k] <= NOP_REG;
      end
    end else begin
      r_addr1   <= w_addr1_next;
      r_addr2   <= w_addr2_next;
      r_rd      <= w_rd_next;
      r_func    <= w_func_next;
      r_memaddr <= w_memaddr_next;
      r_write   <= w_write_next;
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
        if (bus.in_instr[20:17] == NOP_REG) begin
          r_err_rsvd <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rptr       <= r_rptr + (AW+1)'(1);
        r_issued_cnt <= r_issued_cnt + 16'd1;
      end
      if (w_state_next == S_STALL) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      r_sb_v[0]  <= w_valid_next;
      r_sb_rd[0] <= w_rd_next;
      for (int k = 1; k < HAZARD_DEPTH; k++) begin
        r_sb_v[k]  <= r_sb_v[k-1];
        r_sb_rd[k] <= r_sb_rd[k-1];
      end
    end
  end

  assign bus.in_ready    = !rst_n || !w_full;
  assign bus.addr1       = r_addr1;
  assign bus.addr2       = r_addr2;
  assign bus.rd          = r_rd;
  assign bus.func        = r_func;
  assign bus.memaddr     = r_memaddr;
  assign bus.write       = r_write;
  assign bus.issue_valid = (r_state == S_ISSUE);
  assign bus.issued_cnt  = r_issued_cnt;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.err_rsvd    = r_err_rsvd;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_issue_unit
// Brief  : Directed and random stimulus for alu_issue_unit with a queue model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_issue_unit;

  localparam int         FD  = 4;
  localparam int         HD  = 2;
  localparam logic [3:0] NOP = 4'hF;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   wait_cycles = 0;

  alu_issue_unit_if bus ();

  alu_issue_unit #(
    .FIFO_DEPTH   (FD),
    .HAZARD_DEPTH (HD),
    .NOP_REG      (NOP)
  ) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk1 = ~clk1;

  // Reference model: pending queue plus history of the last HD issue slots.
  logic [23:0] mq [$];
  bit          hv [$];
  logic [3:0]  hr [$];
  bit          m_valid = 1'b0;
  logic [3:0]  e_a1, e_a2, e_rd;
  logic [2:0]  e_func;
  logic [7:0]  e_mem;
  logic        e_wr, e_v, e_err;
  logic [15:0] e_iss, e_stall;

  function automatic logic [23:0] mk(input logic [2:0] f, input logic [3:0] d,
                                     input logic [3:0] a, input logic [3:0] b,
                                     input logic w, input logic [7:0] m);
    return {f, d, a, b, w, m};
  endfunction

  always @(posedge clk1) begin
    int  sz0;
    bit  haz, nv;
    logic [3:0]  nrd;
    logic [23:0] h;
    sz0 = mq.size();
    {e_a1, e_a2, e_rd, e_func, e_mem, e_wr, e_v} = {NOP, NOP, NOP, 3'b100, 8'd0, 1'b0, 1'b0};
    if (!rst_n) begin
      mq.delete(); hv.delete(); hr.delete();
      for (int k = 0; k < HD; k++) begin hv.push_back(1'b0); hr.push_back(NOP); end
      e_iss = 0; e_stall = 0; e_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      nv = 1'b0; nrd = NOP;
      if (sz0 > 0) begin
        h = mq[0]; haz = 1'b0;
        for (int k = 0; k < HD; k++)
          if (hv[k] && (h[16:13] == hr[k] || h[12:9] == hr[k])) haz = 1'b1;
        if (haz) e_stall++;
        else begin
          void'(mq.pop_front());
          {e_func, e_rd, e_a1, e_a2, e_wr, e_mem} = h;
          e_v = 1'b1; nv = 1'b1; nrd = h[20:17]; e_iss++;
        end
      end
      hv.push_front(nv); hr.push_front(nrd);
      void'(hv.pop_back()); void'(hr.pop_back());
      if (bus.in_valid && sz0 < FD) begin
        mq.push_back(bus.in_instr);
        if (bus.in_instr[20:17] == NOP) e_err = 1'b1;
      end
    end
  end

  always @(posedge clk1) begin
    logic e_rdy;
    #1;
    if (m_valid) begin
      e_rdy = !rst_n || (mq.size() < FD);
      vectors++;
      if ({bus.issue_valid, bus.func, bus.addr1, bus.addr2, bus.rd, bus.memaddr, bus.write,
           bus.issued_cnt, bus.stall_cnt, bus.err_rsvd, bus.in_ready} !==
          {e_v, e_func, e_a1, e_a2, e_rd, e_mem, e_wr, e_iss, e_stall, e_err, e_rdy}) begin
        miscompares++;
        $display("FAIL cycle t=%0t got v=%b f=%0d a1=%h a2=%h rd=%h m=%h w=%b ic=%0d sc=%0d e=%b rdy=%b want v=%b f=%0d a1=%h a2=%h rd=%h m=%h w=%b ic=%0d sc=%0d e=%b rdy=%b",
                 $time, bus.issue_valid, bus.func, bus.addr1, bus.addr2, bus.rd, bus.memaddr,
                 bus.write, bus.issued_cnt, bus.stall_cnt, bus.err_rsvd, bus.in_ready,
                 e_v, e_func, e_a1, e_a2, e_rd, e_mem, e_wr, e_iss, e_stall, e_err, e_rdy);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [23:0] ins);
    int guard = 0;
    bus.in_instr = ins;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      wait_cycles++; guard++;
      @(negedge clk1);
    end
    if (guard >= 100) begin
      miscompares++;
      $display("FAIL push_timeout got=not_ready want=ready");
    end
    @(negedge clk1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_instr = mk(3'd0, 4'd1, 4'd2, 4'd3, 1'b1, 8'h55);
    // Reset held with a valid instruction presented.
    idle(2);
    check("rst_func",  bus.func, 4);
    check("rst_addr1", bus.addr1, 15);
    check("rst_addr2", bus.addr2, 15);
    check("rst_rd",    bus.rd, 15);
    check("rst_write", bus.write, 0);
    check("rst_cnts",  bus.issued_cnt + bus.stall_cnt, 0);
    check("rst_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    idle(3);
    check("rst_nothing_accepted", bus.issued_cnt, 0);

    // Independent stream.
    do_reset(1);
    push(mk(3'd0, 4'd1, 4'd2, 4'd3, 1'b0, 8'h10));
    push(mk(3'd1, 4'd4, 4'd5, 4'd6, 1'b1, 8'h20));
    push(mk(3'd2, 4'd7, 4'd8, 4'd9, 1'b0, 8'h30));
    idle(5);
    check("indep_issued", bus.issued_cnt, 3);
    check("indep_stall",  bus.stall_cnt, 0);

    // Adjacent RAW.
    do_reset(1);
    push(mk(3'd0, 4'd1, 4'd2, 4'd3, 1'b0, 8'h01));
    push(mk(3'd3, 4'd4, 4'd1, 4'd5, 1'b0, 8'h02));
    idle(6);
    check("adj_stall",  bus.stall_cnt, 2);
    check("adj_issued", bus.issued_cnt, 2);

    // Distance-2 RAW.
    do_reset(1);
    push(mk(3'd0, 4'd1, 4'd2, 4'd3, 1'b0, 8'h01));
    push(mk(3'd4, 4'd6, 4'd7, 4'd8, 1'b0, 8'h02));
    push(mk(3'd5, 4'd9, 4'd1, 4'd0, 1'b1, 8'h03));
    idle(6);
    check("d2_stall",  bus.stall_cnt, 1);
    check("d2_issued", bus.issued_cnt, 3);

    // Backpressure: a dependent chain fills the buffer.
    do_reset(1);
    wait_cycles = 0;
    for (int i = 1; i <= 8; i++)
      push(mk(3'(i), 4'(i), 4'(i - 1), 4'd14, i[0], 8'(8'hA0 + i)));
    idle(30);
    check("bp_saw_full", (wait_cycles > 0) ? 1 : 0, 1);
    check("bp_issued",   bus.issued_cnt, 8);
    check("bp_stall",    bus.stall_cnt, 14);

    // Reset mid-stall, then the reserved destination register.
    do_reset(1);
    push(mk(3'd0, 4'd1, 4'd2, 4'd3, 1'b0, 8'h01));
    push(mk(3'd3, 4'd4, 4'd1, 4'd5, 1'b0, 8'h02));
    idle(1);
    check("ms_in_stall", bus.stall_cnt, 1);
    do_reset(1);
    check("ms_bubble", bus.issue_valid, 0);
    check("ms_issued", bus.issued_cnt, 0);
    idle(4);
    check("ms_drained", bus.issued_cnt, 0);
    push(mk(3'd0, 4'hF, 4'd2, 4'd3, 1'b0, 8'h07));
    idle(1);
    check("err_set", bus.err_rsvd, 1);
    idle(5);
    check("err_sticky", bus.err_rsvd, 1);
    check("err_issued", bus.issued_cnt, 1);
    do_reset(1);
    check("err_cleared", bus.err_rsvd, 0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] a, b, d;
      a = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 5));
      b = 4'($urandom_range(0, 5));
      d = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 5));
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_instr = mk(3'($urandom), d, a, b, 1'($urandom), 8'($urandom));
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk1);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
